// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART: stores {parity error, byte} pairs and
// presents the head entry first-word-fall-through with registered status flags.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wen,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wperr,
  input  logic                    ren,
  input  logic                    flush,
  input  logic                    ovf_clr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rperr,
  output logic                    empty,
  output logic                    full,
  output logic                    afull,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic                wr_acc;
  logic                rd_acc;
  logic                drop;
  logic [CW-1:0]       count_nxt;
  logic [DATA_WIDTH:0] head;

  // When full, a same-cycle pop frees the slot, so the write is still taken.
  always_comb begin
    wr_acc    = wen && (!full || ren) && !flush;
    rd_acc    = ren && !empty && !flush;
    drop      = wen && full && !ren && !flush;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + 1'b1;
        if (rd_acc) rptr <= rptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      afull <= (count_nxt >= CW'(AFULL_LEVEL));
      // A dropped write outranks a clear arriving in the same cycle.
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr || flush)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= {wperr, wdata};
  end

  assign head  = mem[rptr];
  assign rdata = empty ? '0   : head[DATA_WIDTH-1:0];
  assign rperr = empty ? 1'b0 : head[DATA_WIDTH];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed stimulus feeds a scoreboard queue, and an
// independent monitor checks every popped head entry against it.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wen, wperr, ren, flush, ovf_clr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rperr, empty, full, afull, overflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  logic [8:0] sbq [$];
  int         mcount;
  logic       movf;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
    .clk(clk), .reset_n(reset_n), .wen(wen), .wdata(wdata), .wperr(wperr),
    .ren(ren), .flush(flush), .ovf_clr(ovf_clr), .rdata(rdata), .rperr(rperr),
    .empty(empty), .full(full), .afull(afull), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest outstanding entry.
  always @(negedge clk) begin
    if (reset_n && ren && !flush && !empty) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop_head: got %0h with no entry expected at %0t", {rperr, rdata}, $time);
      end else begin
        logic [8:0] exp;
        exp = sbq.pop_front();
        if ({rperr, rdata} !== exp) begin
          errors++;
          $display("FAIL pop_head: got %0h expected %0h at %0t", {rperr, rdata}, exp, $time);
        end
      end
    end
  end

  task automatic chk_flags(input string tag);
    chk({tag, "_count"}, int'(count), mcount);
    chk({tag, "_empty"}, int'(empty), (mcount == 0) ? 1 : 0);
    chk({tag, "_full"},  int'(full),  (mcount == 16) ? 1 : 0);
    chk({tag, "_afull"}, int'(afull), (mcount >= 12) ? 1 : 0);
    chk({tag, "_ovf"},   int'(overflow), int'(movf));
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input string tag, input logic w, input logic [7:0] d, input logic p,
                      input logic r, input logic f, input logic oc);
    logic wacc, racc, drp;
    wen = w; wdata = d; wperr = p; ren = r; flush = f; ovf_clr = oc;
    wacc = w && (mcount < 16 || r);
    racc = r && (mcount > 0);
    drp  = w && (mcount == 16) && !r;
    if (f) begin
      mcount = 0;
      movf   = 1'b0;
      sbq.delete();
    end else begin
      if (wacc) sbq.push_back({p, d});
      mcount = mcount + (wacc ? 1 : 0) - (racc ? 1 : 0);
      if (drp) movf = 1'b1;
      else if (oc) movf = 1'b0;
    end
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    chk_flags(tag);
  endtask

  task automatic wr(input logic [7:0] d);
    step("wr", 1'b1, d, d[0], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step("pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; wen = 1'b0; wdata = 8'h00; wperr = 1'b0;
    ren = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    mcount = 0; movf = 1'b0;
    #23 reset_n = 1'b1;
    @(posedge clk); #1;

    chk_flags("reset");
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_rperr", int'(rperr), 0);

    // Single entry with parity error, falls through immediately.
    step("w5a", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("w5a_rdata", int'(rdata), 8'h5A);
    chk("w5a_rperr", int'(rperr), 1);
    pop();
    chk("pop5a_rdata", int'(rdata), 0);
    chk("pop5a_rperr", int'(rperr), 0);

    // Fill with 0x00..0x0F back to back.
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 10) chk("afull_before", int'(afull), 0);
      if (i == 11) chk("afull_at12", int'(afull), 1);
    end
    chk("full_count", int'(count), 16);
    chk("full_flag", int'(full), 1);

    // Dropped write when full.
    step("drop", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_head", int'(rdata), 8'h00);
    step("ovfclr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovfclr_ovf", int'(overflow), 0);
    step("clr_vs_drop", 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", int'(overflow), 1);

    // Simultaneous write and pop while full.
    step("full_wr_pop", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_wr_pop_count", int'(count), 16);
    chk("full_wr_pop_head", int'(rdata), 8'h01);
    for (int i = 0; i < 16; i++) pop();
    chk("drained_rdata", int'(rdata), 0);

    // Write+pop on empty: pop ignored, write taken.
    step("empty_wr_pop", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_wr_pop_count", int'(count), 1);
    chk("empty_wr_pop_head", int'(rdata), 8'h3C);
    pop();
    pop();

    // Wrap-around with occupancy held between 4 and 5.
    for (int i = 0; i < 4; i++) wr(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, 8'h80 + 8'(i), i[0], (i % 8) != 3, 1'b0, 1'b0);
      if ((i % 8) == 7) pop();
    end
    chk("wrap_count", int'(count), 4);

    // Flush at seven entries with overflow still set.
    while (mcount < 7) wr(8'hC0 + 8'(mcount));
    chk("preflush_ovf", int'(overflow), 1);
    step("flush", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", int'(count), 0);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_rdata", int'(rdata), 0);
    wr(8'h33);
    chk("postflush_head", int'(rdata), 8'h33);
    wr(8'h34);
    wr(8'h35);

    // Asynchronous reset mid-stream.
    #2 reset_n = 1'b0;
    #1;
    mcount = 0; movf = 1'b0; sbq.delete();
    chk_flags("async_rst");
    chk("async_rst_rdata", int'(rdata), 0);
    chk("async_rst_rperr", int'(rperr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    wr(8'h99);
    chk("postrst_head", int'(rdata), 8'h99);
    pop();

    #20;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
